// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream to instruction-memory word loader
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W      = 64,
    parameter int DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CHECK, S_DONE
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHECK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t      state, state_nxt;
    logic [7:0]  len_lo;
    logic [15:0] word_cnt;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] shreg;
    logic        err_q;
    logic        xfer;
    logic [15:0] len_in;
    logic        len_over;
    logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign xfer      = in_valid & in_ready;
    assign len_in    = {in_data, len_lo};
    assign len_over  = {1'b0, len_in} > 17'(DEPTH_WORDS);
    assign last_word = (word_idx + 16'd1) == word_cnt;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LEN0;
            S_LEN0:  if (xfer) state_nxt = S_LEN1;
            S_LEN1: begin
                if (xfer) begin
                    if (len_over)          state_nxt = S_DONE;
                    else if (len_in == '0) state_nxt = S_TAIL;
                    else                   state_nxt = S_DATA;
                end
            end
            S_DATA:  if (xfer && byte_cnt == 2'd3) state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_word ? S_TAIL : S_DATA;
            S_CHECK: if (xfer) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_LEN0;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        wr_en     = 1'b0;
        core_hold = 1'b1;
        done      = 1'b0;
        case (state)
            S_LEN0, S_LEN1, S_DATA, S_CHECK: in_ready = 1'b1;
            S_WRITE: wr_en = 1'b1;
            S_DONE: begin
                core_hold = 1'b0;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    // wr_addr/wr_data are loaded as the word completes, so they are valid
    // throughout the WRITE cycle and hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_lo   <= '0;
            word_cnt <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            err_q    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_q    <= 1'b0;
                        word_idx <= '0;
                        byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                S_LEN0: if (xfer) len_lo <= in_data;
                S_LEN1: begin
                    if (xfer) begin
                        word_cnt <= len_in;
                        if (len_over) err_q <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shreg    <= {in_data, shreg[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ in_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            wr_data <= {in_data, shreg};
                            wr_addr <= ADDR_W'({word_idx, 2'b00});
                        end
                    end
                end
                S_WRITE: word_idx <= word_idx + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: if (xfer && in_data != csum) err_q <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory that the single-cycle core fetches from. It takes a byte stream over a valid/ready handshake, packs the bytes into 32-bit little-endian instruction words, and writes them to consecutive word addresses starting at 0. It holds the core in reset-like stall (`core_hold`) until the image is complete, so that fetch starts at PC 0 only against a fully loaded memory.

## Interface
- `ADDR_W`, 64: width of the write address; matches PC width.
- `DEPTH_WORDS`, 256: instruction memory capacity in 32-bit words.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load; sampled in IDLE and DONE only.
- `in_valid`  in  1  byte available on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `wr_en`  out  1  instruction memory write strobe, one cycle per word.
- `wr_addr`  out  ADDR_W  byte address of the write, a multiple of 4.
- `wr_data`  out  32  instruction word.
- `core_hold`  out  1  core stall/PC hold request.
- `done`  out  1  load finished; level, not a pulse.
- `err`  out  1  load error; valid when `done`=1.

## Operation
- Stream format: `LEN_LO`, `LEN_HI` (16-bit word count N), then 4·N data bytes with the least significant byte of each word first. With `IMEM_LOADER_CHECKSUM_EN` defined, one checksum byte follows.
- A byte transfers on any cycle with `in_valid & in_ready`.
- States and transitions:
  - IDLE: `start`=1 → LEN0.
  - LEN0: on a transfer, latch the low count byte → LEN1.
  - LEN1: on a transfer, latch the high count byte. Then:
    - N > DEPTH_WORDS → DONE with `err`=1; no writes, and the remaining stream is not consumed.
    - N = 0 → CHECK if the checksum is enabled, else DONE.
    - otherwise → DATA.
  - DATA: accept bytes into a shift register. The 4th transfer → WRITE.
  - WRITE: exactly one cycle. `wr_en`=1, `wr_addr`=4·word_idx, `wr_data`=packed word. Then word_idx increments. If word_idx+1 = N → CHECK or DONE; else → DATA.
  - CHECK (macro only): one transfer, then compare → DONE.
  - DONE: `start`=1 → LEN0. This clears `err` and `word_idx`, and raises `core_hold`.
- `in_ready` is 1 only in LEN0, LEN1, DATA and CHECK. It is 0 in IDLE, WRITE and DONE.
- `core_hold` is 1 in every state except DONE.
- `done` is 1 only in DONE.
- `wr_addr` and `wr_data` hold their last written value when `wr_en`=0. Their reset value is 0.
- `start` in any state other than IDLE or DONE is ignored.
- The word index is a 16-bit unsigned value, zero-extended to ADDR_W and shifted left by 2. No wrap is possible, because N ≤ DEPTH_WORDS is enforced.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `core_hold`=1, `done`=0, `err`=0.
- `rst` asserted mid-load returns to IDLE on the next edge. The partial word is discarded and any already-written words are left in memory.
- Latency: the 4th byte of a word transfers at edge k; `wr_en` is high during cycle k+1.
- Peak throughput: 1 word per 5 cycles with `in_valid` held high.
- After the last WRITE (or the CHECK transfer), `done`=1 and `core_hold`=0 from the next cycle.
- `in_valid` gaps stall the current state without losing bytes.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The loader keeps a running 8-bit XOR of all data bytes, starting at 0x00 and excluding the length bytes.
  - The CHECK state consumes one trailing byte. A mismatch sets `err`=1.
  - Words are still written even when the checksum fails.
  - `core_hold` is deasserted regardless of `err`; the system decides what to do with a failed load.
- Undefined: there is no CHECK state, no trailing byte is expected, and `err` is set only by a count overflow.

## Test plan
- Reset, then `start`, then stream 02 00 13 00 00 00 93 00 10 00 → writes 0x00000013 @0 and 0x00100093 @4, each as a 1-cycle `wr_en`. `done`=1, `core_hold`=0, `err`=0.
- Same stream with random `in_valid` gaps → identical writes. `in_ready`=0 in every WRITE cycle.
- Count 0x0101 with DEPTH_WORDS=256 → no `wr_en` ever, `done`=1, `err`=1, `in_ready`=0 afterwards.
- Count 0 → `done`=1 with no writes. With the macro, one checksum byte of 00 is consumed and `err`=0.
- Macro on: one word AA BB CC DD plus checksum 00 → `err`=0. The same word with checksum 01 → word still written at @0 and `err`=1.
- `rst` pulse after 5 data bytes, then a full reload of 1 word 11 22 33 44 → only 0x44332211 @0 is written after the reset, and `core_hold` stays 1 until `done`.
